// File: rtl/wb_memtest_pkg.sv
// wb_memtest_pkg: shared state type, LFSR constants and watchdog limit for
// the Wishbone memory-test master.
package wb_memtest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Galois taps of the pattern generator (right-shifting form).
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

    // An all-zero seed would lock the LFSR, so it is replaced by this value.
    localparam logic [31:0] SEED_ZERO_SUB = 32'h0000_0001;

    // Stalled strobe cycles tolerated before the watchdog aborts the test.
    localparam logic [7:0]  WDOG_LIMIT    = 8'd255;

    // One Galois step: shift right, fold the taps back in when a 1 falls out.
    function automatic logic [31:0] lfsr_advance(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Seed as actually loaded into the LFSR.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? SEED_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/wb_memtest_if.sv
// wb_memtest_if: Wishbone classic bus between the memory tester (master)
// and the memory under test (slave).
interface wb_memtest_if;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wb_memtest_lfsr.sv
// wb_memtest_lfsr: 32-bit Galois LFSR pattern generator. load has priority
// over step; state is the current pattern word.
module wb_memtest_lfsr
    import wb_memtest_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    // Next pattern word: reload from seed or advance by one Galois step.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
            state_d = lfsr_advance(state_q);
        end
    end

    // Pattern register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/wb_memtest_master.sv
// wb_memtest_master: Wishbone master that fills a memory region with an
// LFSR pattern, reads it back and reports mismatches.
// Optional build macro WB_MEMTEST_TIMEOUT_EN adds an 8-bit ack watchdog;
// without it the master waits forever for ack and timeout_o is tied low.
module wb_memtest_master
    import wb_memtest_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = 8,
    parameter logic [31:0] BASE_ADR  = 32'h3000_0000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic [31:0]          seed_i,
    wb_memtest_if.master         wbm,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [15:0]          err_cnt_o,
    output logic [ADR_WIDTH-1:0] fail_adr_o,
    output logic [31:0]          fail_dat_o,
    output logic                 timeout_o
);

    localparam logic [ADR_WIDTH-1:0] IDX_MAX = '1;

    state_t               state_q, state_d;
    logic [ADR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]          seed_q, seed_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [ADR_WIDTH-1:0] fail_adr_q, fail_adr_d;
    logic [31:0]          fail_dat_q, fail_dat_d;
`ifdef WB_MEMTEST_TIMEOUT_EN
    logic                 timeout_q, timeout_d;
    logic [7:0]           wdog_q, wdog_d;
`endif

    logic                 lfsr_load;
    logic                 lfsr_step;
    logic [31:0]          lfsr_seed;
    logic [31:0]          lfsr_state;
    logic [31:0]          seed_in;
    logic                 rd_mismatch;

    wb_memtest_lfsr u_lfsr (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .load  (lfsr_load),
        .seed  (lfsr_seed),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    assign seed_in     = seed_fix(seed_i);
    assign rd_mismatch = (wbm.wbm_dat_i != lfsr_state);

    // Test sequencer: launches one bus transaction at a time, leaves a single
    // idle cycle after every ack, and tracks the read-back error record.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        seed_d     = seed_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_adr_d = fail_adr_q;
        fail_dat_d = fail_dat_q;
`ifdef WB_MEMTEST_TIMEOUT_EN
        timeout_d  = timeout_q;
        wdog_d     = wdog_q;
`endif
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        lfsr_seed  = seed_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d    = ST_WRITE;
                    seed_d     = seed_in;
                    lfsr_load  = 1'b1;
                    lfsr_seed  = seed_in;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    fail_adr_d = '0;
                    fail_dat_d = '0;
`ifdef WB_MEMTEST_TIMEOUT_EN
                    timeout_d  = 1'b0;
                    wdog_d     = '0;
`endif
                end
            end

            ST_WRITE, ST_READ: begin
                if (!cyc_q) begin
                    // Idle cycle is over: present the next transaction.
                    cyc_d = 1'b1;
                    sel_d = 4'hF;
                    we_d  = (state_q == ST_WRITE);
                    adr_d = BASE_ADR + (32'(idx_q) << 2);
                    dat_d = (state_q == ST_WRITE) ? lfsr_state : 32'h0;
`ifdef WB_MEMTEST_TIMEOUT_EN
                    wdog_d = '0;
`endif
                end else if (wbm.wbm_ack_i) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = 4'h0;
                    adr_d = 32'h0;
                    dat_d = 32'h0;
`ifdef WB_MEMTEST_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    if ((state_q == ST_READ) && rd_mismatch) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_d = err_cnt_q + 16'd1;
                        end
                        if (err_cnt_q == 16'h0) begin
                            fail_adr_d = idx_q;
                            fail_dat_d = wbm.wbm_dat_i;
                        end
                    end
                    if (idx_q == IDX_MAX) begin
                        idx_d = '0;
                        if (state_q == ST_WRITE) begin
                            // Replay the same pattern for the read-back pass.
                            lfsr_load = 1'b1;
                            state_d   = ST_READ;
                        end else begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_cnt_d == 16'h0);
                        end
                    end else begin
                        idx_d     = idx_q + ADR_WIDTH'(1);
                        lfsr_step = 1'b1;
                    end
                end
`ifdef WB_MEMTEST_TIMEOUT_EN
                else if (wdog_q == (WDOG_LIMIT - 8'd1)) begin
                    // Responder never answered: abandon the test.
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = 4'h0;
                    adr_d     = 32'h0;
                    dat_d     = 32'h0;
                    wdog_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All sequencer state and every output register, cleared asynchronously.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            seed_q     <= '0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_adr_q <= '0;
            fail_dat_q <= '0;
`ifdef WB_MEMTEST_TIMEOUT_EN
            timeout_q  <= 1'b0;
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seed_q     <= seed_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_adr_q <= fail_adr_d;
            fail_dat_q <= fail_dat_d;
`ifdef WB_MEMTEST_TIMEOUT_EN
            timeout_q  <= timeout_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_cnt_q;
    assign fail_adr_o = fail_adr_q;
    assign fail_dat_o = fail_dat_q;
`ifdef WB_MEMTEST_TIMEOUT_EN
    assign timeout_o  = timeout_q;
`else
    assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_memtest_master.sv
// tb_wb_memtest_master: directed tests for wb_memtest_master with a memory
// responder and a transaction-level model checked on every falling edge.
// Honours WB_MEMTEST_TIMEOUT_EN for the stalled-responder scenario.
`timescale 1ns/1ps
module tb_wb_memtest_master;

    localparam int          ADR_W = 8;
    localparam int          N     = 1 << ADR_W;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       seed;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_cnt;
    logic [ADR_W-1:0]  fail_adr;
    logic [31:0]       fail_dat;
    logic              timeout;

    wb_memtest_if bus ();

    wb_memtest_master #(
        .ADR_WIDTH (ADR_W),
        .BASE_ADR  (BASE)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .seed_i     (seed),
        .wbm        (bus.master),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .err_cnt_o  (err_cnt),
        .fail_adr_o (fail_adr),
        .fail_dat_o (fail_dat),
        .timeout_o  (timeout)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Responder controls, written only by the main sequence.
    int resp_wait_rd = 0;
    bit resp_sticky  = 1'b0;
    bit resp_noack   = 1'b0;
    bit resp_corrupt = 1'b0;

    // Responder state.
    logic [31:0] mem [N];
    logic [31:0] wr_log_adr [$];
    logic [31:0] wr_log_dat [$];
    int          rd_count = 0;
    int          resp_cnt = 0;
    bit          resp_last_ack = 1'b0;
    logic [31:0] resp_word;
    int          resp_idx;

    // Transaction-level reference model.
    logic [31:0]      m_pat [N];
    bit               m_running, m_gap, m_done, m_timeout;
    int               m_txn, m_stall, m_err, m_idx;
    logic [ADR_W-1:0] m_fail_adr;
    logic [31:0]      m_fail_dat;

    int base_wr, base_rd, n_wait, stall_n, stb_seen;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s);
        @(posedge clk);
        #1;
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic waitStb(input int budget);
        int n = 0;
        while (bus.wbm_stb_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stb_launched", 32'(bus.wbm_stb_o), 32'd1);
    endtask

    function automatic logic [31:0] wrDat(input int k);
        return (k < wr_log_dat.size()) ? wr_log_dat[k] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] wrAdr(input int k);
        return (k < wr_log_adr.size()) ? wr_log_adr[k] : 32'hBAD0_BAD0;
    endfunction

    // Memory responder: acks writes at once, reads after resp_wait_rd extra
    // cycles, optionally holds ack one cycle too long or never acks.
    initial begin : responder
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_dat_i = 32'h0;
                resp_cnt      = 0;
                resp_last_ack = 1'b0;
            end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
                resp_word = (bus.wbm_adr_o - BASE) >> 2;
                resp_idx  = int'(resp_word[ADR_W-1:0]);
                if (!resp_noack && resp_cnt >= (bus.wbm_we_o ? 0 : resp_wait_rd)) begin
                    bus.wbm_ack_i = 1'b1;
                    if (bus.wbm_we_o) begin
                        mem[resp_idx] = bus.wbm_dat_o;
                        wr_log_adr.push_back(bus.wbm_adr_o);
                        wr_log_dat.push_back(bus.wbm_dat_o);
                        bus.wbm_dat_i = 32'hDEAD_BEEF;
                    end else begin
                        bus.wbm_dat_i = mem[resp_idx] ^
                                        ((resp_corrupt && resp_idx == 5) ? 32'h1 : 32'h0);
                        rd_count++;
                    end
                    resp_last_ack = 1'b1;
                end else begin
                    bus.wbm_ack_i = 1'b0;
                    bus.wbm_dat_i = 32'hDEAD_BEEF;
                    resp_last_ack = 1'b0;
                end
                resp_cnt++;
            end else begin
                bus.wbm_ack_i = resp_sticky && resp_last_ack;
                bus.wbm_dat_i = 32'hDEAD_BEEF;
                resp_last_ack = 1'b0;
                resp_cnt      = 0;
            end
        end
    end

    // Compare process: check outputs against the model, then advance the
    // model by what the DUT will sample at the next rising edge.
    initial begin : compare
        m_running = 1'b0; m_gap = 1'b0; m_done = 1'b0; m_timeout = 1'b0;
        m_txn = 0; m_stall = 0; m_err = 0; m_fail_adr = '0; m_fail_dat = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_running = 1'b0; m_gap = 1'b0; m_done = 1'b0; m_timeout = 1'b0;
                m_txn = 0; m_stall = 0; m_err = 0; m_fail_adr = '0; m_fail_dat = '0;
                checkOutput("rst_cyc",  32'(bus.wbm_cyc_o), 32'd0);
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_done", 32'(done), 32'd0);
            end else begin
                checkOutput("busy",     32'(busy),     32'(m_running));
                checkOutput("done",     32'(done),     32'(m_done));
                checkOutput("pass",     32'(pass),     32'(m_done && m_err == 0 && !m_timeout));
                checkOutput("err_cnt",  32'(err_cnt),  32'(m_err));
                checkOutput("fail_adr", 32'(fail_adr), 32'(m_fail_adr));
                checkOutput("fail_dat", fail_dat,      m_fail_dat);
                checkOutput("timeout",  32'(timeout),  32'(m_timeout));
                checkOutput("stb",      32'(bus.wbm_stb_o), 32'(m_running && !m_gap));
                checkOutput("cyc",      32'(bus.wbm_cyc_o), 32'(m_running && !m_gap));
                m_idx = m_txn % N;
                if (m_running && !m_gap && bus.wbm_stb_o) begin
                    checkOutput("adr", bus.wbm_adr_o, BASE + 32'(m_idx * 4));
                    checkOutput("we",  32'(bus.wbm_we_o), 32'(m_txn < N));
                    checkOutput("sel", 32'(bus.wbm_sel_o), 32'hF);
                    if (m_txn < N) begin
                        checkOutput("wr_dat", bus.wbm_dat_o, m_pat[m_idx]);
                    end
                end

                if (!m_running) begin
                    if (start) begin
                        m_pat[0] = (seed == 32'h0) ? 32'h1 : seed;
                        for (int k = 1; k < N; k++) begin
                            m_pat[k] = (m_pat[k-1] >> 1) ^
                                       (m_pat[k-1][0] ? 32'h8020_0003 : 32'h0);
                        end
                        m_running = 1'b1; m_gap = 1'b1; m_done = 1'b0; m_timeout = 1'b0;
                        m_txn = 0; m_stall = 0; m_err = 0;
                        m_fail_adr = '0; m_fail_dat = '0;
                    end
                end else if (m_gap) begin
                    m_gap = 1'b0;
                end else if (bus.wbm_ack_i) begin
                    if (m_txn >= N && bus.wbm_dat_i !== m_pat[m_idx]) begin
                        if (m_err == 0) begin
                            m_fail_adr = ADR_W'(m_idx);
                            m_fail_dat = bus.wbm_dat_i;
                        end
                        if (m_err < 65535) m_err++;
                    end
                    m_txn++;
                    m_gap   = 1'b1;
                    m_stall = 0;
                    if (m_txn == 2 * N) begin
                        m_running = 1'b0;
                        m_done    = 1'b1;
                    end
                end else begin
                    m_stall++;
`ifdef WB_MEMTEST_TIMEOUT_EN
                    if (m_stall == 255) begin
                        m_running = 1'b0;
                        m_done    = 1'b1;
                        m_timeout = 1'b1;
                        m_stall   = 0;
                    end
`endif
                end
            end
        end
    end

    // Directed scenarios.
    initial begin : main
        rst   = 1'b1;
        start = 1'b0;
        seed  = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy",    32'(busy),        32'd0);
        checkOutput("reset_done",    32'(done),        32'd0);
        checkOutput("reset_adr",     bus.wbm_adr_o,    32'h0);
        checkOutput("reset_err_cnt", 32'(err_cnt),     32'd0);
        checkOutput("reset_timeout", 32'(timeout),     32'd0);
        rst = 1'b0;

        // Clean pass, seed 1, zero-wait responder.
        base_wr = wr_log_dat.size();
        base_rd = rd_count;
        applyStimulus(32'h1);
        waitDone(3000);
        checkOutput("a_pass",     32'(pass),    32'd1);
        checkOutput("a_err_cnt",  32'(err_cnt), 32'd0);
        checkOutput("a_busy",     32'(busy),    32'd0);
        checkOutput("a_writes",   32'(wr_log_dat.size() - base_wr), 32'd256);
        checkOutput("a_reads",    32'(rd_count - base_rd), 32'd256);
        checkOutput("a_wr0_adr",  wrAdr(base_wr), 32'h3000_0000);
        checkOutput("a_wr0_dat",  wrDat(base_wr), 32'h0000_0001);
        checkOutput("a_wr1_dat",  wrDat(base_wr + 1), 32'h8020_0003);
        checkOutput("a_wr2_dat",  wrDat(base_wr + 2), 32'hC030_0002);
        checkOutput("a_wr255_adr", wrAdr(base_wr + 255), 32'h3000_03FC);
        checkOutput("model_pat5", m_pat[5], 32'hD836_0002);

        // Bit 0 of read word 5 flipped by the responder.
        resp_corrupt = 1'b1;
        applyStimulus(32'h1);
        waitDone(3000);
        checkOutput("b_err_cnt",  32'(err_cnt),  32'd1);
        checkOutput("b_fail_adr", 32'(fail_adr), 32'd5);
        checkOutput("b_fail_dat", fail_dat,      32'hD836_0003);
        checkOutput("b_pass",     32'(pass),     32'd0);
        resp_corrupt = 1'b0;

        // Zero seed, plus a start pulse while the test is running.
        base_wr = wr_log_dat.size();
        applyStimulus(32'h0);
        repeat (40) @(posedge clk);
        #1;
        seed  = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(3000);
        checkOutput("c_wr0_dat", wrDat(base_wr), 32'h0000_0001);
        checkOutput("c_writes",  32'(wr_log_dat.size() - base_wr), 32'd256);
        checkOutput("c_pass",    32'(pass), 32'd1);

        // Two-cycle read ack, ack held into the idle cycle.
        resp_wait_rd = 1;
        resp_sticky  = 1'b1;
        base_wr = wr_log_dat.size();
        base_rd = rd_count;
        applyStimulus(32'hCAFE_F00D);
        waitDone(4000);
        checkOutput("d_wr0_dat", wrDat(base_wr), 32'hCAFE_F00D);
        checkOutput("d_writes",  32'(wr_log_dat.size() - base_wr), 32'd256);
        checkOutput("d_reads",   32'(rd_count - base_rd), 32'd256);
        checkOutput("d_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("d_pass",    32'(pass), 32'd1);
        resp_wait_rd = 0;
        resp_sticky  = 1'b0;

        // Asynchronous reset in the middle of a stalled transaction.
        resp_noack = 1'b1;
        applyStimulus(32'h5);
        waitStb(10);
        @(posedge clk);
        #3;
        checkOutput("e_stb_before_rst", 32'(bus.wbm_stb_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("e_async_cyc",  32'(bus.wbm_cyc_o), 32'd0);
        checkOutput("e_async_stb",  32'(bus.wbm_stb_o), 32'd0);
        checkOutput("e_async_we",   32'(bus.wbm_we_o),  32'd0);
        checkOutput("e_async_sel",  32'(bus.wbm_sel_o), 32'd0);
        checkOutput("e_async_adr",  bus.wbm_adr_o,      32'h0);
        checkOutput("e_async_dat",  bus.wbm_dat_o,      32'h0);
        checkOutput("e_async_busy", 32'(busy),          32'd0);
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        resp_noack = 1'b0;
        stb_seen   = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.wbm_stb_o) stb_seen++;
        end
        checkOutput("e_no_reissue", 32'(stb_seen), 32'd0);

        // Responder that never acks.
        resp_noack = 1'b1;
        applyStimulus(32'h1);
        waitStb(10);
        stall_n = 0;
        while (bus.wbm_stb_o && stall_n < 400) begin
            @(negedge clk);
            stall_n++;
        end
`ifdef WB_MEMTEST_TIMEOUT_EN
        checkOutput("f_stall_cycles", 32'(stall_n), 32'd255);
        checkOutput("f_cyc",     32'(bus.wbm_cyc_o), 32'd0);
        checkOutput("f_timeout", 32'(timeout), 32'd1);
        checkOutput("f_done",    32'(done),    32'd1);
        checkOutput("f_pass",    32'(pass),    32'd0);
`else
        checkOutput("f_stall_cycles", 32'(stall_n), 32'd400);
        checkOutput("f_cyc",     32'(bus.wbm_cyc_o), 32'd1);
        checkOutput("f_timeout", 32'(timeout), 32'd0);
        checkOutput("f_busy",    32'(busy),    32'd1);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        resp_noack = 1'b0;
        @(negedge clk);
        checkOutput("f_idle_after_rst", 32'(busy), 32'd0);

        n_wait = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound so a wedged run still terminates.
    initial begin : global_guard
        #500_000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/wb_memtest_master.md
WB_MEMTEST_MASTER -- requirements
Module: wb_memtest_master

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 8: word-address bits, so the test region is 2**ADR_WIDTH 32-bit words.
REQ-002 SHALL have parameter BASE_ADR, default 32'h3000_0000: byte address of word 0.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, ports wb_clk_i and wb_rst_i.
REQ-004 SHALL have the following ports.
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  async active-high reset.
- start_i  in  1  one-cycle test launch.
- seed_i  in  32  LFSR seed, sampled on accepted start.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  1 = write.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  responder acknowledge.
- wbm_dat_i  in  32  read data.
- busy_o  out  1  test running.
- done_o  out  1  test finished; held until the next start.
- pass_o  out  1  valid when done_o=1.
- err_cnt_o  out  16  mismatch count, saturating.
- fail_adr_o  out  ADR_WIDTH  word index of the first mismatch.
- fail_dat_o  out  32  read data of the first mismatch.
- timeout_o  out  1  watchdog abort (WB_MEMTEST_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-005 SHALL implement FSM IDLE -> WRITE -> READ -> DONE; from DONE, start_i SHALL return to WRITE.
REQ-006 SHALL accept start_i only in IDLE or DONE, and SHALL ignore it while busy_o=1.
REQ-007 On an accepted start, the block SHALL:
- clear err_cnt_o, fail_adr_o, fail_dat_o, done_o and timeout_o;
- load the LFSR with seed_i, substituting 32'h1 when seed_i=0;
- set word index i=0.
REQ-008 Pattern SHALL be a 32-bit Galois LFSR with taps mask 32'h8020_0003, advanced once per acked transaction; data for word i is the LFSR state after i advances.
REQ-009 Every transaction SHALL drive wbm_adr_o = BASE_ADR + (i<<2) and wbm_sel_o = 4'hF.
REQ-010 Transaction handshake SHALL be:
- assert cyc and stb together with adr, dat and we;
- hold them all stable until wbm_ack_i is sampled high;
- deassert cyc and stb for exactly one cycle before the next transaction.
REQ-011 wbm_ack_i SHALL be ignored while stb=0.
REQ-012 WRITE SHALL issue 2**ADR_WIDTH writes with wbm_we_o=1, i=0..max.
REQ-013 After the write at i=max, the block SHALL reload the LFSR from the latched seed, set i=0 and enter READ.
REQ-014 READ SHALL issue 2**ADR_WIDTH reads with wbm_we_o=0 and compare wbm_dat_i with the pattern in the ack cycle.
REQ-015 On each read mismatch, err_cnt_o SHALL increment and saturate at 16'hFFFF; the first mismatch SHALL capture fail_adr_o and fail_dat_o.
REQ-016 After the read at i=max is acked, the block SHALL enter DONE with done_o=1, busy_o=0 and pass_o=(err_cnt_o==0).
REQ-017 busy_o SHALL be 1 exactly in WRITE and READ.
REQ-018 The index counter SHALL wrap from max to 0 only at phase transitions; no transaction SHALL address beyond max.

Reset
REQ-019 Asserting wb_rst_i SHALL immediately, asynchronously, set the state to IDLE.
REQ-020 Asserting wb_rst_i SHALL immediately zero every output, including cyc and stb mid-transaction.
REQ-021 No transaction SHALL be reissued after reset deassertion without a new start_i.

Configuration
REQ-022 With WB_MEMTEST_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles with stb=1 and no ack, and clear on each ack.
REQ-023 When the watchdog reaches 255, the block SHALL:
- drop cyc and stb;
- set timeout_o=1;
- enter DONE with pass_o=0.
REQ-024 Without WB_MEMTEST_TIMEOUT_EN, there SHALL be no watchdog, the block SHALL wait indefinitely for ack, and timeout_o SHALL be constant 0.

Structure
REQ-025 Package wb_memtest_pkg SHALL hold the state typedef, the LFSR taps mask, the zero-seed substitute and the watchdog limit.
REQ-026 The LFSR SHALL be a sub-module wb_memtest_lfsr with ports load, seed, step and state.

Verification
REQ-027 Reset: assert wb_rst_i mid-cycle -> all outputs 0 in the same cycle, with no clock edge needed.
REQ-028 Clean pass:
- setup: ADR_WIDTH=8, zero-wait responder, seed 32'h1;
- first write: adr 32'h3000_0000, dat 32'h1, second dat 32'h8020_0003;
- result: 256 writes, 256 reads, done=1, pass=1, err_cnt=0.
REQ-029 Corruption: responder flips bit 0 of read word 5 -> err_cnt=1, fail_adr=5, fail_dat = pattern5^1, pass=0.
REQ-030 Seed 0 and start held busy:
- seed 0: first write data 32'h1;
- start_i pulsed while busy: sequence unchanged.
REQ-031 No-ack responder with WB_MEMTEST_TIMEOUT_EN -> after 255 stalled cycles cyc=0, timeout=1, done=1, pass=0.
REQ-032 Two-cycle read-ack responder: stb held until ack, exactly one idle cycle between transactions, no double-counted ack.
